// File: rtl/dft_scheduler.sv
// Channel sweep scheduler between the ADC/DFT front end and the result consumer.
// Settles each enabled channel, waits for one DFT result, and holds it until it is accepted.
module dft_scheduler #(
    parameter int SETTLE_CYCLES  = 68,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [7:0]         chan_mask,
    input  logic               err_clr,
    output logic [2:0]         adc_channel,
    input  logic               dft_valid,
    input  logic signed [31:0] mag0,
    input  logic signed [31:0] mag1,
    input  logic signed [31:0] mag2,
    input  logic signed [31:0] mag3,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2:0]         res_chan,
    output logic signed [31:0] res_mag0,
    output logic signed [31:0] res_mag1,
    output logic signed [31:0] res_mag2,
    output logic signed [31:0] res_mag3,
    output logic               busy,
    output logic               timeout_err,
    output logic               frame_done
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        SETTLE,
        WAIT,
        PRESENT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [2:0]    last_chan;
    logic [2:0]    pick_chan;
    logic [2:0]    cand;
    logic          pick_hit;
    logic [7:0]    sweep_mask;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] wait_cnt;
    logic          go;
    logic          settle_done;
    logic          timeout_hit;
    logic          handshake;
    logic          last_in_sweep;

    // Round-robin search upward from last_chan; the 8th candidate is last_chan itself.
    always_comb begin
        pick_chan = last_chan;
        pick_hit  = 1'b0;
        cand      = '0;
        for (int i = 1; i <= 8; i++) begin
            cand = last_chan + 3'(i);
            if (!pick_hit && chan_mask[cand]) begin
                pick_chan = cand;
                pick_hit  = 1'b1;
            end
        end
    end

    assign go            = enable && (chan_mask != 8'd0);
    assign settle_done   = (settle_cnt == '0);
    assign timeout_hit   = (state == WAIT) && !dft_valid &&
                           (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign handshake     = res_valid && res_ready;
    assign last_in_sweep = ((sweep_mask >> last_chan) >> 1) == 8'd0;
    assign busy          = (state != IDLE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (go) state_nx = PICK;
            PICK:    state_nx = go ? SETTLE : IDLE;
            SETTLE:  if (settle_done) state_nx = WAIT;
            WAIT: begin
                if (dft_valid)        state_nx = PRESENT;
                else if (timeout_hit) state_nx = PICK;
            end
            PRESENT: if (handshake) state_nx = PICK;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_chan   <= 3'd7;
            adc_channel <= 3'd0;
            sweep_mask  <= 8'd0;
            settle_cnt  <= '0;
            wait_cnt    <= '0;
            res_valid   <= 1'b0;
            res_chan    <= 3'd0;
            res_mag0    <= '0;
            res_mag1    <= '0;
            res_mag2    <= '0;
            res_mag3    <= '0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                PICK: begin
                    if (go) begin
                        adc_channel <= pick_chan;
                        last_chan   <= pick_chan;
                        sweep_mask  <= chan_mask;
                        settle_cnt  <= SW'(SETTLE_CYCLES - 1);
                    end
                end
                SETTLE: begin
                    if (settle_done) wait_cnt   <= '0;
                    else             settle_cnt <= settle_cnt - 1'b1;
                end
                WAIT: begin
                    if (dft_valid) begin
                        res_mag0  <= mag0;
                        res_mag1  <= mag1;
                        res_mag2  <= mag2;
                        res_mag3  <= mag3;
                        res_chan  <= adc_channel;
                        res_valid <= 1'b1;
                    end else if (timeout_hit) begin
                        frame_done <= last_in_sweep;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                PRESENT: begin
                    if (handshake) begin
                        res_valid  <= 1'b0;
                        frame_done <= last_in_sweep;
                    end
                end
                default: ;
            endcase
            // A new timeout outranks a clear request in the same cycle.
            if (timeout_hit)  timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dft_scheduler.sv
// Scoreboard bench for dft_scheduler: directed sweeps, settle gating,
// backpressure, timeout, stop/wrap and mid-run reset.
module tb_dft_scheduler;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               enable;
    logic [7:0]         chan_mask;
    logic               err_clr;
    logic [2:0]         adc_channel;
    logic               dft_valid;
    logic signed [31:0] mag0, mag1, mag2, mag3;
    logic               res_valid;
    logic               res_ready;
    logic [2:0]         res_chan;
    logic signed [31:0] res_mag0, res_mag1, res_mag2, res_mag3;
    logic               busy;
    logic               timeout_err;
    logic               frame_done;

    typedef struct {
        logic [2:0]  ch;
        logic [31:0] m0;
        logic [31:0] m1;
        logic [31:0] m2;
        logic [31:0] m3;
        logic        fd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic fd_pend = 1'b0;
    logic fd_exp  = 1'b0;

    dft_scheduler #(
        .SETTLE_CYCLES (68),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .chan_mask  (chan_mask),
        .err_clr    (err_clr),
        .adc_channel(adc_channel),
        .dft_valid  (dft_valid),
        .mag0       (mag0),
        .mag1       (mag1),
        .mag2       (mag2),
        .mag3       (mag3),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_chan   (res_chan),
        .res_mag0   (res_mag0),
        .res_mag1   (res_mag1),
        .res_mag2   (res_mag2),
        .res_mag3   (res_mag3),
        .busy       (busy),
        .timeout_err(timeout_err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [2:0] ch, input logic fd);
        sb.push_back('{ch, mag0, mag1, mag2, mag3, fd});
    endtask

    task automatic set_mags(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
        mag0 = a;
        mag1 = b;
        mag2 = c;
        mag3 = d;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 200);
        chk(name, n, 71);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_adc"}, adc_channel, 0);
        chk({tag, "_rv"}, res_valid, 0);
        chk({tag, "_rch"}, res_chan, 0);
        chk({tag, "_m0"}, res_mag0, 0);
        chk({tag, "_m1"}, res_mag1, 0);
        chk({tag, "_m2"}, res_mag2, 0);
        chk({tag, "_m3"}, res_mag3, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_terr"}, timeout_err, 0);
        chk({tag, "_fd"}, frame_done, 0);
    endtask

    // Monitor: pops on every handshake, checks frame_done on the following cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (fd_pend) begin
                chk("frame_done", frame_done, fd_exp);
                fd_pend = 1'b0;
            end
            if (reset_n && res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("res_chan", res_chan, e.ch);
                    chk("res_mag0", res_mag0, e.m0);
                    chk("res_mag1", res_mag1, e.m1);
                    chk("res_mag2", res_mag2, e.m2);
                    chk("res_mag3", res_mag3, e.m3);
                    fd_exp  = e.fd;
                    fd_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        reset_n   = 1'b0;
        enable    = 1'b0;
        chan_mask = 8'h00;
        err_clr   = 1'b0;
        dft_valid = 1'b0;
        res_ready = 1'b0;
        set_mags(0, 0, 0, 0);
        tick(3);
        reset_vals("rst");
        reset_n = 1'b1;
        tick(2);
        chk("idle_busy", busy, 0);

        // Basic sweep over channels 0 and 2, dft_valid held high throughout.
        chan_mask = 8'h05;
        enable    = 1'b1;
        dft_valid = 1'b1;
        res_ready = 1'b1;
        set_mags(100, 7, -3, 7);
        push(3'd0, 1'b0);
        push(3'd2, 1'b1);
        push(3'd0, 1'b0);
        wait_valid("lat_c0");
        chk("adc_c0", adc_channel, 0);
        wait_valid("lat_c2");
        chk("adc_c2", adc_channel, 2);
        wait_valid("lat_c0b");
        enable    = 1'b0;
        dft_valid = 1'b0;
        tick(3);
        chk("basic_idle", busy, 0);

        // Settle gating and backpressure on channel 2.
        set_mags(32'h12345678, -1, 0, 42);
        res_ready = 1'b0;
        enable    = 1'b1;
        tick(11);
        dft_valid = 1'b1;
        set_mags(-999, -999, -999, -999);
        tick(1);
        dft_valid = 1'b0;
        set_mags(32'h12345678, -1, 0, 42);
        tick(57);
        dft_valid = 1'b1;
        set_mags(-555, -555, -555, -555);
        tick(1);
        chk("settle_no_early", res_valid, 0);
        set_mags(32'h12345678, -1, 0, 42);
        push(3'd2, 1'b1);
        tick(1);
        dft_valid = 1'b0;
        chk("settle_capture", res_valid, 1);
        set_mags(-777, -777, -777, -777);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            dft_valid = (i == 10 || i == 30);
            tick(1);
            if (!res_valid || res_mag0 !== 32'h12345678 || res_mag1 !== -1 ||
                res_mag2 !== 0 || res_mag3 !== 42 || res_chan !== 3'd2)
                bad++;
        end
        dft_valid = 1'b0;
        chk("bp_hold", bad, 0);
        res_ready = 1'b1;
        enable    = 1'b0;
        tick(4);
        chk("bp_idle", busy, 0);
        chk("bp_single", res_valid, 0);

        // Timeout on channel 1 with TIMEOUT_CYCLES=16.
        chan_mask = 8'h02;
        enable    = 1'b1;
        tick(85);
        chk("to_early", timeout_err, 0);
        tick(1);
        chk("to_set", timeout_err, 1);
        chk("to_fd", frame_done, 1);
        chk("to_busy", busy, 1);
        tick(34);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("to_clr", timeout_err, 0);
        tick(49);
        chk("to2_early", timeout_err, 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("to2_prio", timeout_err, 1);
        chk("to2_fd", frame_done, 1);
        enable = 1'b0;
        tick(2);
        chk("to_idle", busy, 0);
        chk("to_adc", adc_channel, 1);

        // Channel 7 only: drop enable in WAIT, then re-enable.
        chan_mask = 8'h80;
        enable    = 1'b1;
        dft_valid = 1'b1;
        res_ready = 1'b0;
        set_mags(-1000, 2000, -3000, 4000);
        tick(70);
        enable = 1'b0;
        chk("c7_wait", res_valid, 0);
        tick(1);
        chk("c7_valid", res_valid, 1);
        chk("c7_chan", res_chan, 7);
        push(3'd7, 1'b1);
        dft_valid = 1'b0;
        tick(4);
        res_ready = 1'b1;
        tick(3);
        chk("c7_idle", busy, 0);
        set_mags(1, 2, 3, 4);
        push(3'd7, 1'b1);
        enable    = 1'b1;
        dft_valid = 1'b1;
        wait_valid("lat_c7b");
        chk("c7_adc", adc_channel, 7);
        enable    = 1'b0;
        dft_valid = 1'b0;
        tick(3);
        chk("c7b_idle", busy, 0);

        // Reset while a result is presented.
        res_ready = 1'b0;
        enable    = 1'b1;
        dft_valid = 1'b1;
        set_mags(11, 22, 33, 44);
        wait_valid("lat_rst");
        chk("rst_pres", res_valid, 1);
        enable    = 1'b0;
        dft_valid = 1'b0;
        reset_n   = 1'b0;
        tick(1);
        reset_vals("midrst");
        reset_n = 1'b1;
        tick(2);
        chk("post_busy", busy, 0);
        chk("post_rv", res_valid, 0);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dft_scheduler.md
DFT_SCHEDULER -- requirements
Module: dft_scheduler

Interface
REQ-001 Parameter SETTLE_CYCLES, default 68, cycles waited after a channel switch before a DFT result is accepted (4 samples x 17 cycles).
REQ-002 Parameter TIMEOUT_CYCLES, default 1023, maximum cycles waited in WAIT for dft_valid.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 enable  in  1  permits new channel sweeps.
REQ-006 chan_mask  in  8  one bit per ADC channel; 1 = include in sweep.
REQ-007 err_clr  in  1  clears timeout_err.
REQ-008 adc_channel  out  3  channel index driven to the DFT/ADC block.
REQ-009 dft_valid  in  1  one-cycle pulse from the DFT block: mag0..mag3 are valid.
REQ-010 mag0, mag1, mag2, mag3  in  32 each, signed  DFT bin magnitudes.
REQ-011 res_valid  out  1  result bank holds an unconsumed result.
REQ-012 res_ready  in  1  consumer (HDMI side) accepts the result.
REQ-013 res_chan  out  3  channel of the presented result.
REQ-014 res_mag0..res_mag3  out  32 each, signed  captured magnitudes.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 timeout_err  out  1  sticky flag: a channel timed out.
REQ-017 frame_done  out  1  one-cycle pulse when a sweep of all enabled channels completes.

Function
REQ-018 The FSM SHALL have states IDLE, PICK, SETTLE, WAIT and PRESENT.
REQ-019 IDLE: go to PICK when enable=1 and chan_mask!=0; otherwise remain in IDLE.
REQ-020 PICK (1 cycle): choose the lowest set bit of chan_mask strictly above last_chan, wrapping 7->0; if none is found, choose last_chan itself when its bit is set.
REQ-021 PICK: if chan_mask=0 or enable=0, go to IDLE with adc_channel unchanged.
REQ-022 PICK: otherwise register adc_channel and last_chan to the chosen index, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE.
REQ-023 SETTLE: decrement the counter each cycle; dft_valid is ignored; when the counter reaches 0, load the timeout counter with 0 and go to WAIT (SETTLE lasts SETTLE_CYCLES cycles).
REQ-024 WAIT, dft_valid=1: capture mag0..mag3 into res_mag0..3 and adc_channel into res_chan, set res_valid=1 on the next cycle, and go to PRESENT.
REQ-025 WAIT, no dft_valid: increment the timeout counter each cycle.
REQ-026 WAIT, timeout: when the counter equals TIMEOUT_CYCLES-1 with no dft_valid, set timeout_err, capture nothing, and go to PICK (channel skipped).
REQ-027 WAIT, simultaneous dft_valid and timeout: dft_valid wins and no error is set.
REQ-028 PRESENT: hold res_valid and all res_* stable until res_valid and res_ready are both high on a clock edge.
REQ-029 On the PRESENT handshake cycle: clear res_valid next cycle and go to PICK; res_mag/res_chan keep their last values.
REQ-030 dft_valid pulses in PICK, SETTLE or PRESENT SHALL be dropped; the bank is never overwritten while res_valid=1.
REQ-031 enable and chan_mask are sampled only in IDLE and PICK; deasserting enable lets the in-flight channel finish its handshake.
REQ-032 frame_done pulses for one cycle on a handshake (or timeout skip) of a channel with no set chan_mask bit above it.
REQ-033 timeout_err: set has priority over err_clr in the same cycle; otherwise err_clr clears it next cycle.
REQ-034 adc_channel SHALL change only on the PICK->SETTLE edge.
REQ-035 Counter widths: settle counter at least clog2(SETTLE_CYCLES) bits; timeout counter at least clog2(TIMEOUT_CYCLES) bits; no wrap inside a state.

Reset
REQ-036 With reset_n=0 at a posedge, the next state SHALL be IDLE, with last_chan=7, adc_channel=0, res_valid=0, res_chan=0, res_mag0..3=0, busy=0, timeout_err=0, frame_done=0, and all counters 0.
REQ-037 Reset mid-operation (any state) SHALL abandon the channel with no handshake and no error.

Verification
REQ-038 Basic: reset, mask=8'h05, enable=1, dft_valid pulse with mag0=100, mag1=7, mag2=-3, mag3=7 after settle, res_ready=1 -> channel 0 presented (res_chan=0, res_mag2=-3), then channel 2 with frame_done=1 at its handshake, then channel 0 again.
REQ-039 Settle gating: dft_valid on cycle 10 of SETTLE -> ignored; first capture only after 68 SETTLE cycles.
REQ-040 Backpressure: res_ready=0 for 50 cycles and two dft_valid pulses in PRESENT -> res_* unchanged, single handshake when res_ready=1.
REQ-041 Timeout: mask=8'h02, TIMEOUT_CYCLES=16, no dft_valid -> timeout_err=1 after 16 WAIT cycles, returns to PICK, frame_done pulses; err_clr the same cycle as a second timeout -> flag stays 1.
REQ-042 Stop/wrap: mask=8'h80, enable dropped in WAIT -> channel 7 completes its handshake, then IDLE with busy=0; re-enable -> picks 7 again.
REQ-043 Reset in PRESENT with res_valid=1 -> next cycle res_valid=0, busy=0, all outputs at reset values.
